spiral_mcm: RTL and testbench

Parametrised, pipelined multiple-constant multiplier for the odd/even DCT coefficient sets of HEVC transforms sizes 4/8/16/32. One signed sample is multiplied by all coefficients of the selected set using shift-add networks only, with no hardware multipliers. The block sits in the tq datapath ahead of the butterfly accumulators. It replaces the fixed, combinational 32-point odd-coefficient spiral with a registered, flow-controlled, size-selectable version.

---
 rtl/spiral_pkg.sv | 38 +++
 rtl/spiral_pipe_stage.sv | 28 ++
 rtl/spiral_mcm.sv | 162 ++++++++++++++++
 tb/tb_spiral_mcm.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spiral_pkg.sv
// Shared types and tables for the spiral multiple-constant multiplier.
// The coefficient table is the arithmetic reference; the datapath itself is shift/add only.
package spiral_pkg;

   typedef enum logic [1:0] {
      SZ4  = 2'd0,
      SZ8  = 2'd1,
      SZ16 = 2'd2,
      SZ32 = 2'd3
   } size_e;

   localparam int LANES  = 16;
   localparam int NTERMS = 8;

   // slot of each shared partial term inside the stage-1 register
   localparam int T1  = 0;
   localparam int T9  = 1;
   localparam int T17 = 2;
   localparam int T31 = 3;
   localparam int T3  = 4;
   localparam int T5  = 5;
   localparam int T7  = 6;
   localparam int T25 = 7;

   localparam int COEF [4][LANES] = '{
      '{64, 83, 36,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0, 0},
      '{89, 75, 50, 18,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  0, 0},
      '{90, 87, 80, 70, 57, 43, 25,  9,  0,  0,  0,  0,  0,  0,  0, 0},
      '{90, 90, 88, 85, 82, 78, 73, 67, 61, 54, 46, 38, 31, 22, 13, 4}
   };

   localparam int SET_LEN [4] = '{3, 4, 8, 16};

   function automatic int set_len(input size_e s);
      return SET_LEN[s];
   endfunction

endpackage

// File: rtl/spiral_pipe_stage.sv
// One valid/ready register slice; loads when empty or when its content leaves this cycle.
module spiral_pipe_stage #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         up_valid,
   output logic         up_ready,
   input  logic [W-1:0] up_data,
   output logic         dn_valid,
   input  logic         dn_ready,
   output logic [W-1:0] dn_data
);

   assign up_ready = !dn_valid | dn_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dn_valid <= 1'b0;
         dn_data  <= '0;
      end else if (up_ready) begin
         dn_valid <= up_valid;
         // data only moves with a real sample so a drained stage keeps its last value
         if (up_valid) dn_data <= up_data;
      end
   end

endmodule

// File: rtl/spiral_mcm.sv
// Two-stage pipelined multiple-constant multiplier for the HEVC DCT coefficient sets.
// Build option SPIRAL_MCM_SAT_EN saturates each lane to OUT_W; otherwise lanes wrap.
module spiral_mcm
   import spiral_pkg::*;
#(
   parameter int IN_W  = 17,
   parameter int OUT_W = IN_W + 7,
   parameter int LANES = spiral_pkg::LANES
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   i_valid,
   output logic                   i_ready,
   input  logic [IN_W-1:0]        i_data,
   input  logic [1:0]             i_size,
   input  logic                   i_last,
   output logic                   o_valid,
   input  logic                   o_ready,
   output logic [LANES*OUT_W-1:0] o_data,
   output logic [1:0]             o_size,
   output logic                   o_last
);

   localparam int IW   = IN_W + 8;
   localparam int S1_W = 3 + NTERMS * IW;
   localparam int S2_W = 3 + LANES * OUT_W;

`ifdef SPIRAL_MCM_SAT_EN
   localparam logic signed [IW+OUT_W-1:0] MAXV = {{(IW+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [IW+OUT_W-1:0] MINV = {{(IW+1){1'b1}}, {(OUT_W-1){1'b0}}};
`endif

   function automatic logic [OUT_W-1:0] size_lane(input logic signed [IW-1:0] p);
`ifdef SPIRAL_MCM_SAT_EN
      logic signed [IW+OUT_W-1:0] w;
      w = (IW+OUT_W)'(p);
      if (w > MAXV) return MAXV[OUT_W-1:0];
      if (w < MINV) return MINV[OUT_W-1:0];
      return OUT_W'(p);
`else
      return OUT_W'(p);
`endif
   endfunction

   // ---------------- S1: shared partial terms ----------------
   logic signed [IW-1:0]         x;
   logic [NTERMS-1:0][IW-1:0]    terms;

   assign x = {{8{i_data[IN_W-1]}}, i_data};

   always_comb begin
      terms      = '0;
      terms[T1]  = x;
      terms[T9]  = x + (x <<< 3);
      terms[T17] = x + (x <<< 4);
      terms[T31] = (x <<< 5) - x;
      terms[T3]  = x + (x <<< 1);
      terms[T5]  = x + (x <<< 2);
      terms[T7]  = (x <<< 3) - x;
      terms[T25] = x + (x <<< 3) + (x <<< 4);
   end

   logic [S1_W-1:0] s1_d;
   logic            s1_v;
   logic            s1_rdy;

   spiral_pipe_stage #(.W(S1_W)) u_s1 (
      .clk      (clk),
      .rst_n    (rst_n),
      .up_valid (i_valid),
      .up_ready (i_ready),
      .up_data  ({i_size, i_last, terms}),
      .dn_valid (s1_v),
      .dn_ready (s1_rdy),
      .dn_data  (s1_d)
   );

   logic [1:0]                s1_size;
   logic                      s1_last;
   logic [NTERMS-1:0][IW-1:0] s1_t;
   logic signed [IW-1:0]      p1, p9, p17, p31, p3, p5, p7, p25;

   assign {s1_size, s1_last, s1_t} = s1_d;
   assign p1  = s1_t[T1];
   assign p9  = s1_t[T9];
   assign p17 = s1_t[T17];
   assign p31 = s1_t[T31];
   assign p3  = s1_t[T3];
   assign p5  = s1_t[T5];
   assign p7  = s1_t[T7];
   assign p25 = s1_t[T25];

   // ---------------- S2: lane products and set selection ----------------
   logic signed [IW-1:0]         prod [LANES];
   logic [LANES-1:0][OUT_W-1:0]  lanes;

   always_comb begin
      for (int k = 0; k < LANES; k++) prod[k] = '0;
      case (s1_size)
         SZ4: begin
            prod[0] = p1 <<< 6;
            prod[1] = (p5 <<< 4) + (p5 <<< 1) - p7;
            prod[2] = p9 <<< 2;
         end
         SZ8: begin
            prod[0] = (p1 <<< 6) + p25;
            prod[1] = (p25 <<< 1) + p25;
            prod[2] = p25 <<< 1;
            prod[3] = p9 <<< 1;
         end
         SZ16: begin
            prod[0] = (p5 <<< 4) + (p5 <<< 1);
            prod[1] = (p3 <<< 5) - p9;
            prod[2] = p5 <<< 4;
            prod[3] = (p7 <<< 3) + (p7 <<< 1);
            prod[4] = (p1 <<< 6) - p7;
            prod[5] = p25 + (p9 <<< 1);
            prod[6] = p25;
            prod[7] = p9;
         end
         default: begin
            prod[0]  = (p5 <<< 4) + (p5 <<< 1);
            prod[1]  = (p5 <<< 4) + (p5 <<< 1);
            prod[2]  = (p9 <<< 3) + (p1 <<< 4);
            prod[3]  = (p17 <<< 2) + p17;
            prod[4]  = (p1 <<< 6) + (p9 <<< 1);
            prod[5]  = (p1 <<< 6) + (p7 <<< 1);
            prod[6]  = (p1 <<< 6) + p9;
            prod[7]  = (p1 <<< 6) + p3;
            prod[8]  = (p1 <<< 6) - p3;
            prod[9]  = (p1 <<< 6) - (p5 <<< 1);
            prod[10] = (p1 <<< 5) + (p7 <<< 1);
            prod[11] = (p1 <<< 5) + (p3 <<< 1);
            prod[12] = p31;
            prod[13] = p25 - p3;
            prod[14] = p9 + (p1 <<< 2);
            prod[15] = p1 <<< 2;
         end
      endcase
   end

   always_comb begin
      lanes = '0;
      for (int k = 0; k < LANES; k++) lanes[k] = size_lane(prod[k]);
   end

   logic [S2_W-1:0] s2_d;

   spiral_pipe_stage #(.W(S2_W)) u_s2 (
      .clk      (clk),
      .rst_n    (rst_n),
      .up_valid (s1_v),
      .up_ready (s1_rdy),
      .up_data  ({s1_size, s1_last, lanes}),
      .dn_valid (o_valid),
      .dn_ready (o_ready),
      .dn_data  (s2_d)
   );

   assign {o_size, o_last, o_data} = s2_d;

endmodule

// File: tb/tb_spiral_mcm.sv
// Directed bench for spiral_mcm: golden vectors, mixed sizes, backpressure, reset and extremes.
module tb_spiral_mcm;
   import spiral_pkg::*;

   localparam int IN_W  = 17;
   localparam int OUT_W = IN_W + 7;
   localparam int O16   = 16;

   logic                    clk = 1'b0;
   logic                    rst_n = 1'b0;
   logic                    i_valid = 1'b0;
   logic [IN_W-1:0]         i_data = '0;
   logic [1:0]              i_size = '0;
   logic                    i_last = 1'b0;
   logic                    o_ready = 1'b0;
   logic                    i_ready, o_valid, o_last;
   logic [LANES*OUT_W-1:0]  o_data;
   logic [1:0]              o_size;
   logic                    i_ready16, o_valid16, o_last16;
   logic [LANES*O16-1:0]    o_data16;
   logic [1:0]              o_size16;

   int compared = 0;
   int mism     = 0;

   spiral_mcm u_dut (
      .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_ready(i_ready), .i_data(i_data),
      .i_size(i_size), .i_last(i_last), .o_valid(o_valid), .o_ready(o_ready),
      .o_data(o_data), .o_size(o_size), .o_last(o_last)
   );

   spiral_mcm #(.OUT_W(O16)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_ready(i_ready16), .i_data(i_data),
      .i_size(i_size), .i_last(i_last), .o_valid(o_valid16), .o_ready(o_ready),
      .o_data(o_data16), .o_size(o_size16), .o_last(o_last16)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   typedef struct {
      longint x;
      int     sz;
      bit     last;
   } smp_t;

   longint vx [16];
   int     vs [16];
   bit     vl [16];
   logic [15:0] pat = 16'b1011_0010_1110_0101;

   task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mism++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic signed [63:0] lane(input int k);
      logic signed [OUT_W-1:0] v;
      v = o_data[k*OUT_W +: OUT_W];
      return v;
   endfunction

   function automatic logic signed [63:0] lane16(input int k);
      logic signed [O16-1:0] v;
      v = o_data16[k*O16 +: O16];
      return v;
   endfunction

   function automatic logic signed [63:0] exp_lane(input longint x, input int sz, input int k);
      if (k < SET_LEN[sz]) return x * COEF[sz][k];
      return 0;
   endfunction

   task automatic check_sample(input string tag, input longint x, input int sz, input bit last);
      for (int k = 0; k < LANES; k++)
         chk($sformatf("%s lane%0d", tag, k), lane(k), exp_lane(x, sz, k));
      chk({tag, " o_size"}, o_size, sz);
      chk({tag, " o_last"}, o_last, last);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input longint x, input int sz, input bit last);
      i_data = x[IN_W-1:0];
      i_size = sz[1:0];
      i_last = last;
   endtask

   // Streams n samples from vx/vs/vl, checking order, content, stability and i_ready.
   task automatic run_stream(input string tag, input int n, input bit bp, output int cycles);
      smp_t q [$];
      int   sent, got, cyc;
      bit   fire_in, fire_out, prev_stall;
      logic [LANES*OUT_W-1:0] prev_d;
      logic [1:0] prev_s;
      logic prev_l;
      sent = 0; got = 0; cyc = 0; prev_stall = 0;
      prev_d = '0; prev_s = '0; prev_l = 1'b0;
      while (got < n && cyc < 400) begin
         o_ready = bp ? pat[cyc % 16] : 1'b1;
         i_valid = (sent < n);
         if (sent < n) drive(vx[sent], vs[sent], vl[sent]);
         #1;
         chk({tag, " i_ready"}, i_ready, !(q.size() == 2 && !o_ready));
         if (prev_stall) begin
            chk({tag, " stable data"}, o_data === prev_d, 1);
            chk({tag, " stable size"}, o_size, prev_s);
            chk({tag, " stable last"}, o_last, prev_l);
         end
         if (o_valid) begin
            if (q.size() == 0) chk({tag, " spurious o_valid"}, o_valid, 0);
            else check_sample(tag, q[0].x, q[0].sz, q[0].last);
         end
         fire_in    = i_valid && i_ready;
         fire_out   = o_valid && o_ready;
         prev_stall = o_valid && !o_ready;
         prev_d = o_data; prev_s = o_size; prev_l = o_last;
         step();
         if (fire_out) begin
            void'(q.pop_front());
            got++;
         end
         if (fire_in) begin
            q.push_back('{vx[sent], vs[sent], vl[sent]});
            sent++;
         end
         cyc++;
      end
      i_valid = 1'b0;
      o_ready = 1'b1;
      chk({tag, " delivered"}, got, n);
      #1;
      chk({tag, " drained"}, o_valid, 0);
      cycles = cyc;
   endtask

   initial begin
      int cyc;
      longint exp16;

      // reset state
      #12;
      chk("rst o_valid", o_valid, 0);
      chk("rst i_ready", i_ready, 1);
      chk("rst lane0", lane(0), 0);
      chk("rst lane15", lane(15), 0);
      chk("rst o_size", o_size, 0);
      chk("rst o_last", o_last, 0);
      step();
      rst_n = 1'b1;
      step();

      // golden vectors: back-to-back 32pt then 16pt
      o_ready = 1'b1;
      i_valid = 1'b1;
      drive(1, 3, 1'b1);
      step();
      drive(-65536, 2, 1'b0);
      chk("gold lat1 o_valid", o_valid, 0);
      step();
      i_valid = 1'b0;
      chk("gold o_valid", o_valid, 1);
      check_sample("gold32", 1, 3, 1'b1);
      chk("gold32 lane3 const", lane(3), 85);
      chk("gold32 lane15 const", lane(15), 4);
      step();
      chk("gold16 o_valid", o_valid, 1);
      check_sample("gold16", -65536, 2, 1'b0);
      chk("gold16 lane0 const", lane(0), -5898240);
      chk("gold16 lane7 const", lane(7), -589824);
      chk("gold16 lane8 const", lane(8), 0);
      step();
      chk("gold drain", o_valid, 0);

      // mixed sizes back to back: four consecutive outputs
      vx[0] = 1234;   vs[0] = 0; vl[0] = 1'b1;
      vx[1] = -777;   vs[1] = 1; vl[1] = 1'b0;
      vx[2] = 32767;  vs[2] = 2; vl[2] = 1'b1;
      vx[3] = -1;     vs[3] = 3; vl[3] = 1'b0;
      run_stream("mixed", 4, 1'b0, cyc);
      chk("mixed cycles", cyc, 6);

      // backpressure
      vx[0] = 5;      vs[0] = 3; vl[0] = 1'b0;
      vx[1] = -3;     vs[1] = 2; vl[1] = 1'b1;
      vx[2] = 40000;  vs[2] = 1; vl[2] = 1'b0;
      vx[3] = -40000; vs[3] = 0; vl[3] = 1'b1;
      vx[4] = 17;     vs[4] = 3; vl[4] = 1'b1;
      vx[5] = -12345; vs[5] = 3; vl[5] = 1'b0;
      vx[6] = 999;    vs[6] = 0; vl[6] = 1'b0;
      vx[7] = 0;      vs[7] = 2; vl[7] = 1'b1;
      vx[8] = 65535;  vs[8] = 1; vl[8] = 1'b0;
      vx[9] = -2;     vs[9] = 2; vl[9] = 1'b1;
      run_stream("bp", 10, 1'b1, cyc);

      // reset with two samples in flight
      o_ready = 1'b0;
      i_valid = 1'b1;
      drive(321, 3, 1'b1);
      step();
      drive(-321, 1, 1'b1);
      step();
      i_valid = 1'b0;
      chk("rstmid full i_ready", i_ready, 0);
      chk("rstmid full o_valid", o_valid, 1);
      rst_n = 1'b0;
      #1;
      chk("rstmid o_valid", o_valid, 0);
      chk("rstmid i_ready", i_ready, 1);
      step();
      step();
      rst_n = 1'b1;
      o_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         step();
         chk($sformatf("rstmid stale c%0d", c), o_valid, 0);
      end

      // narrow-output build: 1000 x 90 does not fit in 16 bits
`ifdef SPIRAL_MCM_SAT_EN
      exp16 = 32767;
`else
      exp16 = 24464;
`endif
      i_valid = 1'b1;
      drive(1000, 3, 1'b1);
      step();
      i_valid = 1'b0;
      step();
      chk("cfg o_valid", o_valid, 1);
      chk("cfg wide lane0", lane(0), 90000);
      chk("cfg16 o_valid", o_valid16, 1);
      chk("cfg16 i_ready", i_ready16, 1);
      chk("cfg16 lane0", lane16(0), exp16);
      chk("cfg16 lane15", lane16(15), 4000);
      chk("cfg16 o_size", o_size16, 3);
      chk("cfg16 o_last", o_last16, 1);
      step();

      // extremes across all sizes under backpressure
      for (int s = 0; s < 4; s++) begin
         vx[2*s]   = 65535;  vs[2*s]   = s; vl[2*s]   = 1'b1;
         vx[2*s+1] = -65536; vs[2*s+1] = s; vl[2*s+1] = 1'b0;
      end
      run_stream("extreme", 8, 1'b1, cyc);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
      $finish;
   end

endmodule
